sd_wb_scheduler: RTL

Wishbone slave-side controller for the SD host. It decodes the 5-bit bus address map into:
- a 16-entry config register file;
- command-exec and data-exec launches;
- host FIFO push/pop.

---
 rtl/sd_wb_pkg.sv | 26 ++
 rtl/sd_wb_scheduler_if.sv | 24 ++
 rtl/sd_engine_tracker.sv | 94 +++++++++
 rtl/sd_wb_scheduler.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sd_wb_pkg.sv
// Shared constants for the SD host Wishbone scheduler: address map, FSM encoding, status bits.
package sd_wb_pkg;

    localparam int unsigned ADR_W     = 5;
    localparam int unsigned NUM_REGS  = 16;
    localparam int unsigned REG_IDX_W = $clog2(NUM_REGS);

    localparam logic [ADR_W-1:0] ADR_CMD_EXEC  = 5'd16;
    localparam logic [ADR_W-1:0] ADR_FIFO_WR   = 5'd17;
    localparam logic [ADR_W-1:0] ADR_FIFO_RD   = 5'd18;
    localparam logic [ADR_W-1:0] ADR_DATA_EXEC = 5'd19;

    localparam int unsigned STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_FIFO_WAIT = 2'd1;
    localparam state_t ST_RESP      = 2'd2;

    // Bit positions inside the engine status word
    localparam int unsigned STAT_CMD_BUSY  = 0;
    localparam int unsigned STAT_DATA_BUSY = 1;
    localparam int unsigned STAT_CMD_TMO   = 2;
    localparam int unsigned STAT_DATA_TMO  = 3;

endpackage

// File: rtl/sd_wb_scheduler_if.sv
// Wishbone slave-side bus bundle between the host bus master and the SD scheduler.
interface sd_wb_scheduler_if
    import sd_wb_pkg::*;
#(
    parameter int unsigned DATA_W = 128
);
    logic              strobe_i;
    logic              we_i;
    logic [ADR_W-1:0]  adr_i;
    logic [DATA_W-1:0] wb_data_i;
    logic [DATA_W-1:0] wb_data_o;
    logic              ack_o;
    logic              error_o;

    modport slave (
        input  strobe_i, we_i, adr_i, wb_data_i,
        output wb_data_o, ack_o, error_o
    );

    modport master (
        output strobe_i, we_i, adr_i, wb_data_i,
        input  wb_data_o, ack_o, error_o
    );
endinterface

// File: rtl/sd_engine_tracker.sv
// Busy / timeout bookkeeping for the command and data engines with one shared watchdog counter.
module sd_engine_tracker #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic cmd_start,
    input  logic data_start,
    input  logic cmd_done,
    input  logic data_done,
    output logic cmd_busy,
    output logic data_busy,
    output logic cmd_timeout,
    output logic data_timeout,
    output logic abort
);
    localparam int unsigned    CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // cnt holds the number of cycles the active engine has been running, start cycle included
    logic [CNT_W-1:0] cnt;
    logic             any_start;
    logic             any_busy;
    logic             expire;
    logic             cmd_done_ok;
    logic             data_done_ok;
    logic             cmd_expire;
    logic             data_expire;

    assign any_start    = cmd_start | data_start;
    assign any_busy     = cmd_busy | data_busy;
    assign expire       = any_busy & ~any_start & (cnt == CNT_LAST);
    // done is ignored while idle and during the start pulse itself
    assign cmd_done_ok  = cmd_done & cmd_busy & ~cmd_start;
    assign data_done_ok = data_done & data_busy & ~data_start;
    // a done arriving together with expiry wins over the abort
    assign cmd_expire   = expire & cmd_busy & ~cmd_done_ok;
    assign data_expire  = expire & data_busy & ~data_done_ok;

    // Watchdog counter: restarts on a launch, idles at zero when nothing is running
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (any_start) begin
            cnt <= CNT_W'(1);
        end else if (!any_busy || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Command engine busy / timeout flags
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_busy    <= 1'b0;
            cmd_timeout <= 1'b0;
        end else if (cmd_start) begin
            cmd_busy    <= 1'b1;
            cmd_timeout <= 1'b0;
        end else if (cmd_done_ok) begin
            cmd_busy    <= 1'b0;
        end else if (cmd_expire) begin
            cmd_busy    <= 1'b0;
            cmd_timeout <= 1'b1;
        end
    end

    // Data engine busy / timeout flags
    always_ff @(posedge clk) begin
        if (reset) begin
            data_busy    <= 1'b0;
            data_timeout <= 1'b0;
        end else if (data_start) begin
            data_busy    <= 1'b1;
            data_timeout <= 1'b0;
        end else if (data_done_ok) begin
            data_busy    <= 1'b0;
        end else if (data_expire) begin
            data_busy    <= 1'b0;
            data_timeout <= 1'b1;
        end
    end

    // One-cycle abort pulse when either engine overruns
    always_ff @(posedge clk) begin
        if (reset) begin
            abort <= 1'b0;
        end else begin
            abort <= cmd_expire | data_expire;
        end
    end

endmodule

// File: rtl/sd_wb_scheduler.sv
// Wishbone slave controller for the SD host: register file, engine launch sequencing, host FIFO access.
module sd_wb_scheduler
    import sd_wb_pkg::*;
#(
    parameter int unsigned REG_W   = 32,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                       wb_clock,
    input  logic                       reset,
    sd_wb_scheduler_if.slave           bus,
    output logic                       cmd_start_o,
    output logic                       data_start_o,
    input  logic                       cmd_done_i,
    input  logic                       data_done_i,
    output logic                       abort_o,
    output logic                       fifo_wr_o,
    input  logic                       fifo_full_i,
    output logic                       fifo_rd_o,
    input  logic                       fifo_empty_i,
    input  logic [DATA_W-1:0]          host_data_i,
    output logic [NUM_REGS*REG_W-1:0]  regs_o
);
    state_t                           state;
    state_t                           state_nxt;
    logic [NUM_REGS-1:0][REG_W-1:0]   regs;
    logic                             reg_we;
    logic                             ack_nxt;
    logic                             err_nxt;
    logic [DATA_W-1:0]                rdata_nxt;
    logic                             cmd_start_nxt;
    logic                             data_start_nxt;
    logic                             fifo_wr_nxt;
    logic                             fifo_rd_nxt;
    logic                             cmd_busy;
    logic                             data_busy;
    logic                             cmd_timeout;
    logic                             data_timeout;
    logic                             eng_busy;
    logic [DATA_W-1:0]                status;

    assign eng_busy = cmd_busy | data_busy;
    assign regs_o   = regs;

    sd_engine_tracker #(
        .TIMEOUT (TIMEOUT)
    ) u_tracker (
        .clk          (wb_clock),
        .reset        (reset),
        .cmd_start    (cmd_start_o),
        .data_start   (data_start_o),
        .cmd_done     (cmd_done_i),
        .data_done    (data_done_i),
        .cmd_busy     (cmd_busy),
        .data_busy    (data_busy),
        .cmd_timeout  (cmd_timeout),
        .data_timeout (data_timeout),
        .abort        (abort_o)
    );

    // Engine status word returned on reads of either exec address
    always_comb begin
        status                 = '0;
        status[STAT_CMD_BUSY]  = cmd_busy;
        status[STAT_DATA_BUSY] = data_busy;
        status[STAT_CMD_TMO]   = cmd_timeout;
        status[STAT_DATA_TMO]  = data_timeout;
    end

    // Next state and next registered outputs; every response is decided when the strobe is taken
    always_comb begin
        state_nxt      = state;
        ack_nxt        = 1'b0;
        err_nxt        = 1'b0;
        rdata_nxt      = '0;
        cmd_start_nxt  = 1'b0;
        data_start_nxt = 1'b0;
        fifo_wr_nxt    = 1'b0;
        fifo_rd_nxt    = 1'b0;
        reg_we         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.strobe_i) begin
                    state_nxt = ST_RESP;
                    if (!bus.adr_i[ADR_W-1]) begin
                        ack_nxt = 1'b1;
                        if (bus.we_i) begin
                            reg_we = 1'b1;
                        end else begin
                            rdata_nxt = DATA_W'(regs[bus.adr_i[REG_IDX_W-1:0]]);
                        end
                    end else begin
                        case (bus.adr_i)
                            ADR_CMD_EXEC, ADR_DATA_EXEC: begin
                                if (!bus.we_i) begin
                                    ack_nxt   = 1'b1;
                                    rdata_nxt = status;
                                end else if (eng_busy) begin
                                    err_nxt = 1'b1;
                                end else begin
                                    ack_nxt        = 1'b1;
                                    cmd_start_nxt  = (bus.adr_i == ADR_CMD_EXEC);
                                    data_start_nxt = (bus.adr_i == ADR_DATA_EXEC);
                                end
                            end
                            ADR_FIFO_WR: begin
                                if (bus.we_i && !fifo_full_i) begin
                                    ack_nxt     = 1'b1;
                                    fifo_wr_nxt = 1'b1;
                                end else begin
                                    err_nxt = 1'b1;
                                end
                            end
                            ADR_FIFO_RD: begin
                                if (!bus.we_i && !fifo_empty_i) begin
                                    fifo_rd_nxt = 1'b1;
                                    state_nxt   = ST_FIFO_WAIT;
                                end else begin
                                    err_nxt = 1'b1;
                                end
                            end
                            default: begin
                                err_nxt = 1'b1;
                            end
                        endcase
                    end
                end
            end
            ST_FIFO_WAIT: begin
                state_nxt = ST_RESP;
                ack_nxt   = 1'b1;
                rdata_nxt = host_data_i;
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered bus / engine / FIFO outputs
    always_ff @(posedge wb_clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            bus.ack_o     <= 1'b0;
            bus.error_o   <= 1'b0;
            bus.wb_data_o <= '0;
            cmd_start_o   <= 1'b0;
            data_start_o  <= 1'b0;
            fifo_wr_o     <= 1'b0;
            fifo_rd_o     <= 1'b0;
        end else begin
            state         <= state_nxt;
            bus.ack_o     <= ack_nxt;
            bus.error_o   <= err_nxt;
            bus.wb_data_o <= rdata_nxt;
            cmd_start_o   <= cmd_start_nxt;
            data_start_o  <= data_start_nxt;
            fifo_wr_o     <= fifo_wr_nxt;
            fifo_rd_o     <= fifo_rd_nxt;
        end
    end

    // Config register file
    always_ff @(posedge wb_clock) begin
        if (reset) begin
            regs <= '0;
        end else if (reg_we) begin
            regs[bus.adr_i[REG_IDX_W-1:0]] <= bus.wb_data_i[REG_W-1:0];
        end
    end

endmodule
